// File: rtl/fizzbuzz_pkg.sv
// rtl/fizzbuzz_pkg.sv - shared types, ASCII constants and expected-character helpers
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    ST_LINE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  typedef enum logic [1:0] {
    KIND_NUM,
    KIND_FIZZ,
    KIND_BUZZ,
    KIND_FIZZBUZZ
  } line_kind_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_i  = 8'h69;
  localparam logic [7:0] ASCII_z  = 8'h7A;
  localparam logic [7:0] ASCII_b  = 8'h62;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_u  = 8'h75;
  localparam logic [7:0] ASCII_0  = 8'h30;

  // Text lengths before the trailing "\r\n"
  localparam logic [3:0] LEN_FIZZ     = 4'd4;
  localparam logic [3:0] LEN_BUZZ     = 4'd4;
  localparam logic [3:0] LEN_FIZZBUZZ = 4'd8;

  function automatic line_kind_e line_kind(input logic [1:0] mod3, input logic [2:0] mod5);
    line_kind_e k;
    if (mod3 == 2'd0 && mod5 == 3'd0) k = KIND_FIZZBUZZ;
    else if (mod3 == 2'd0)            k = KIND_FIZZ;
    else if (mod5 == 3'd0)            k = KIND_BUZZ;
    else                              k = KIND_NUM;
    return k;
  endfunction

  // Numbers drop leading zeros, so length follows the highest non-zero digit
  function automatic logic [3:0] text_len(input line_kind_e kind, input logic [3:0] h,
                                          input logic [3:0] t);
    logic [3:0] len;
    case (kind)
      KIND_FIZZ:     len = LEN_FIZZ;
      KIND_BUZZ:     len = LEN_BUZZ;
      KIND_FIZZBUZZ: len = LEN_FIZZBUZZ;
      default:       len = (h != 4'd0) ? 4'd3 : ((t != 4'd0) ? 4'd2 : 4'd1);
    endcase
    return len;
  endfunction

  function automatic logic [7:0] exp_char(input line_kind_e kind, input logic [3:0] h,
                                          input logic [3:0] t, input logic [3:0] o,
                                          input logic [3:0] idx);
    logic [3:0] tlen;
    logic [3:0] pos;
    logic [3:0] d;
    logic [7:0] c;
    tlen = text_len(kind, h, t);
    pos  = idx + (4'd3 - tlen);
    d    = o;
    c    = ASCII_LF;
    if (idx == tlen) begin
      c = ASCII_CR;
    end else if (idx < tlen) begin
      case (kind)
        KIND_FIZZ: begin
          case (idx)
            4'd0:    c = ASCII_F;
            4'd1:    c = ASCII_i;
            default: c = ASCII_z;
          endcase
        end
        KIND_BUZZ: begin
          case (idx)
            4'd0:    c = ASCII_B;
            4'd1:    c = ASCII_u;
            default: c = ASCII_z;
          endcase
        end
        KIND_FIZZBUZZ: begin
          case (idx)
            4'd0:    c = ASCII_F;
            4'd1:    c = ASCII_i;
            4'd4:    c = ASCII_b;
            4'd5:    c = ASCII_u;
            default: c = ASCII_z;
          endcase
        end
        default: begin
          case (pos)
            4'd0:    d = h;
            4'd1:    d = t;
            default: d = o;
          endcase
          c = ASCII_0 + {4'b0000, d};
        end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/fizzbuzz_checker_if.sv
// rtl/fizzbuzz_checker_if.sv - serial input and status outputs of the checker
interface fizzbuzz_checker_if;
  logic       in;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       frame_err;
  logic [7:0] led;

  modport master (output in, input done, pass, err_count, frame_err, led);
  modport slave  (input in, output done, pass, err_count, frame_err, led);
endinterface

// File: rtl/fizzbuzz_checker_bcd.sv
// rtl/fizzbuzz_checker_bcd.sv - three-digit BCD up-counter starting at 1
module bcd_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [3:0] r_h, r_t, r_o;

  // Decimal increment with carry between digits; the sequence starts at n = 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= 4'd0;
      r_t <= 4'd0;
      r_o <= 4'd1;
    end else if (i_inc) begin
      if (r_o != 4'd9) begin
        r_o <= r_o + 4'd1;
      end else begin
        r_o <= 4'd0;
        if (r_t != 4'd9) begin
          r_t <= r_t + 4'd1;
        end else begin
          r_t <= 4'd0;
          r_h <= (r_h == 4'd9) ? 4'd0 : r_h + 4'd1;
        end
      end
    end
  end

  assign o_hundreds = r_h;
  assign o_tens     = r_t;
  assign o_ones     = r_o;

endmodule

// File: rtl/fizzbuzz_checker_rx.sv
// rtl/fizzbuzz_checker_rx.sv - 8N1 serial receiver with mid-bit sampling
module serial_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_valid_nxt, w_ferr_nxt;
  logic             r_meta, r_sync, r_prev;
  logic             r_valid, r_ferr;

  // Synchroniser, edge history and all receiver state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_meta  <= in;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Bit timing: half a bit to the start-bit centre, then whole bits
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (r_prev && !r_sync) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          // A start bit that is high again at its centre was a glitch
          w_state_nxt = r_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_sync) w_valid_nxt = 1'b1;
          else        w_ferr_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign data      = r_shift;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

endmodule

// File: rtl/fizzbuzz_checker.sv
// rtl/fizzbuzz_checker.sv - FizzBuzz line checker; optional watchdog via FIZZBUZZ_CHECK_TIMEOUT_EN
module fizzbuzz_checker
  import fizzbuzz_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int LAST_N       = 100
) (
  input  logic              clk,
  input  logic              rst,
  fizzbuzz_checker_if.slave link
);

  localparam logic [3:0] LAST_H = 4'((LAST_N / 100) % 10);
  localparam logic [3:0] LAST_T = 4'((LAST_N / 10) % 10);
  localparam logic [3:0] LAST_O = 4'(LAST_N % 10);

  logic [7:0]  w_rx_data;
  logic        w_rx_valid, w_rx_ferr;
  logic [3:0]  w_h, w_t, w_o;
  chk_state_e  r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_mod3;
  logic [2:0]  r_mod5;
  logic [7:0]  r_err;
  logic        r_frame_err;
  logic        w_err_inc, w_advance, w_last, w_inc_n, w_match, w_timeout;
  line_kind_e  w_kind;
  logic [7:0]  w_exp;

  serial_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .in        (link.in),
    .data      (w_rx_data),
    .valid     (w_rx_valid),
    .frame_err (w_rx_ferr)
  );

  bcd_counter u_bcd (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_inc_n),
    .o_hundreds (w_h),
    .o_tens     (w_t),
    .o_ones     (w_o)
  );

  assign w_kind  = line_kind(r_mod3, r_mod5);
  assign w_exp   = exp_char(w_kind, w_h, w_t, w_o, r_idx);
  // Expected characters are 7-bit, so a set bit 7 can never match
  assign w_match = !w_rx_data[7] && (w_rx_data == w_exp);
  assign w_last  = (w_h == LAST_H) && (w_t == LAST_T) && (w_o == LAST_O);
  assign w_inc_n = w_advance && !w_last;

  // Checker state, character index, residues and error bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LINE;
      r_idx       <= 4'd0;
      r_mod3      <= 2'd1;
      r_mod5      <= 3'd1;
      r_err       <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_inc_n) begin
        r_mod3 <= (r_mod3 == 2'd2) ? 2'd0 : r_mod3 + 2'd1;
        r_mod5 <= (r_mod5 == 3'd4) ? 3'd0 : r_mod5 + 3'd1;
      end
      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
      if (w_rx_ferr) r_frame_err <= 1'b1;
    end
  end

  // Line comparison and resynchronisation on "\n"
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_inc   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_LINE: begin
        if (w_rx_valid) begin
          if (w_match) begin
            if (w_rx_data == ASCII_LF) w_advance = 1'b1;
            else                       w_idx_nxt = r_idx + 4'd1;
          end else begin
            w_err_inc = 1'b1;
            if (w_rx_data == ASCII_LF) w_advance   = 1'b1;
            else                       w_state_nxt = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        if (w_rx_valid && w_rx_data == ASCII_LF) w_advance = 1'b1;
      end
      ST_DONE: begin
      end
      default: w_state_nxt = ST_LINE;
    endcase
    if (w_advance) begin
      w_idx_nxt   = 4'd0;
      w_state_nxt = w_last ? ST_DONE : ST_LINE;
    end
  end

`ifdef FIZZBUZZ_CHECK_TIMEOUT_EN
  localparam int TO_CYCLES = 64 * CLKS_PER_BIT;
  localparam int WD_W      = $clog2(TO_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  // Watchdog on cycles since the last received byte, idle once done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_rx_valid || r_state == ST_DONE) r_wd <= '0;
      else if (r_wd != WD_W'(TO_CYCLES))    r_wd <= r_wd + WD_W'(1);
      if (r_wd == WD_W'(TO_CYCLES)) r_timeout <= 1'b1;
    end
  end

  assign w_timeout = r_timeout;
  assign link.led  = {w_t, r_timeout, 1'b0, r_state};
`else
  assign w_timeout = 1'b0;
  assign link.led  = {w_t, 2'b00, r_state};
`endif

  assign link.done      = (r_state == ST_DONE);
  assign link.pass      = (r_state == ST_DONE) && (r_err == 8'd0) && !r_frame_err && !w_timeout;
  assign link.err_count = r_err;
  assign link.frame_err = r_frame_err;

endmodule
